// File: rtl/jt12_sh_ring_if.sv
// Slot-bus bundle for jt12_sh_ring: per-slot write controls in, ring taps and slot timing out.
interface jt12_sh_ring_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned SW    = 5
);
    logic             clk_en;
    logic [WIDTH-1:0] din;
    logic             we;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] tap;
    logic [SW-1:0]    slot;
    logic             first;
    logic             last;

    modport master (
        output clk_en, din, we, clr,
        input  dout, tap, slot, first, last
    );

    modport slave (
        input  clk_en, din, we, clr,
        output dout, tap, slot, first, last
    );
endinterface

// File: rtl/jt12_sh_ring.sv
// Clock-enabled per-slot shift ring with load/recirculate/clear on stage 1,
// a mid-chain tap and a free-running slot counter with cycle-boundary flags.
module jt12_sh_ring #(
    parameter int unsigned     WIDTH  = 5,
    parameter int unsigned     STAGES = 24,
    parameter int unsigned     TAP    = 12,
    parameter logic [WIDTH-1:0] RSTVAL = '0,
    parameter int unsigned     SW     = $clog2(STAGES)
) (
    input  logic           clk,
    input  logic           rst_n,
    jt12_sh_ring_if.slave  bus
);

    logic [WIDTH-1:0] stage_q [1:STAGES];
    logic [WIDTH-1:0] stage_d [1:STAGES];
    logic [SW-1:0]    slot_q;
    logic [SW-1:0]    slot_d;

    // Next ring contents: clr beats we, otherwise the last stage wraps around.
    always_comb begin
        stage_d = stage_q;
        if (bus.clr) begin
            stage_d[1] = RSTVAL;
        end else if (bus.we) begin
            stage_d[1] = bus.din;
        end else begin
            stage_d[1] = stage_q[STAGES];
        end
        for (int unsigned i = 2; i <= STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Explicit wrap so non-power-of-two depths keep slot alignment.
    always_comb begin
        slot_d = slot_q + SW'(1);
        if (slot_q == SW'(STAGES - 1)) begin
            slot_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i <= STAGES; i++) begin
                stage_q[i] <= RSTVAL;
            end
            slot_q <= '0;
        end else if (bus.clk_en) begin
            stage_q <= stage_d;
            slot_q  <= slot_d;
        end
    end

    assign bus.dout  = stage_q[STAGES];
    assign bus.tap   = stage_q[TAP];
    assign bus.slot  = slot_q;
    assign bus.first = (slot_q == '0);
    assign bus.last  = (slot_q == SW'(STAGES - 1));

endmodule

// File: tb/tb_jt12_sh_ring.sv
// Directed bench for jt12_sh_ring: a 24-stage ring and a 3-stage ring sharing one clock.
module tb_jt12_sh_ring;

    localparam logic [4:0] RV = 5'h1F;

    logic clk;
    logic rst_n_big;
    logic rst_n_small;
    int   n_checks;
    int   n_pass;

    logic [4:0] m_stage [1:24];
    int         m_slot;

    jt12_sh_ring_if #(.WIDTH(5), .SW(5)) bus_big ();
    jt12_sh_ring_if #(.WIDTH(5), .SW(2)) bus_small ();

    jt12_sh_ring #(.WIDTH(5), .STAGES(24), .TAP(12), .RSTVAL(RV)) u_big (
        .clk   (clk),
        .rst_n (rst_n_big),
        .bus   (bus_big)
    );

    jt12_sh_ring #(.WIDTH(5), .STAGES(3), .TAP(3), .RSTVAL(RV)) u_small (
        .clk   (clk),
        .rst_n (rst_n_small),
        .bus   (bus_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock on the big ring, advancing the reference model from the applied inputs.
    task automatic tick_big();
        logic [4:0] nxt [1:24];
        int         ns;
        nxt = m_stage;
        ns  = m_slot;
        if (!rst_n_big) begin
            for (int i = 1; i <= 24; i++) nxt[i] = RV;
            ns = 0;
        end else if (bus_big.clk_en) begin
            nxt[1] = bus_big.clr ? RV : (bus_big.we ? bus_big.din : m_stage[24]);
            for (int i = 2; i <= 24; i++) nxt[i] = m_stage[i-1];
            ns = (m_slot == 23) ? 0 : m_slot + 1;
        end
        @(posedge clk);
        #1;
        m_stage = nxt;
        m_slot  = ns;
    endtask

    task automatic tick_small();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_big      = 1'b0;
        bus_big.clk_en = 1'b1;
        bus_big.we     = 1'b1;
        bus_big.din    = 5'h03;
        tick_big();
        bus_big.clk_en = 1'b0;
        tick_big();
        rst_n_big = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus_big.din = 5'(k);
            tick_big();
            n_checks++;
            if (bus_big.dout !== RV || bus_big.tap !== RV || bus_big.slot !== 5'd0 ||
                bus_big.first !== 1'b1 || bus_big.last !== 1'b0)
                $display("FAIL reset_hold k=%0d dout=%h tap=%h slot=%0d first=%b last=%b required dout=tap=1f slot=0 first=1 last=0",
                         k, bus_big.dout, bus_big.tap, bus_big.slot, bus_big.first, bus_big.last);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        bus_big.clk_en = 1'b1;
        bus_big.we     = 1'b1;
        bus_big.clr    = 1'b0;
        for (int k = 0; k < 24; k++) begin
            n_checks++;
            if (bus_big.slot !== 5'(k) || bus_big.first !== (k == 0) || bus_big.last !== (k == 23))
                $display("FAIL fill_slot k=%0d slot=%0d first=%b last=%b required slot=%0d first=%b last=%b",
                         k, bus_big.slot, bus_big.first, bus_big.last, k, (k == 0), (k == 23));
            else n_pass++;
            bus_big.din = 5'(k + 1);
            tick_big();
            n_checks++;
            if (bus_big.tap !== ((k + 1 >= 12) ? 5'(k - 10) : RV))
                $display("FAIL fill_tap edge=%0d tap=%h required %h", k + 1, bus_big.tap,
                         (k + 1 >= 12) ? 5'(k - 10) : RV);
            else n_pass++;
        end
        n_checks++;
        if (bus_big.dout !== 5'd1 || bus_big.slot !== 5'd0 || bus_big.first !== 1'b1)
            $display("FAIL fill_done dout=%h slot=%0d first=%b required dout=01 slot=0 first=1",
                     bus_big.dout, bus_big.slot, bus_big.first);
        else n_pass++;
    endtask

    task automatic test_recirculate();
        int n_first;
        int n_last;
        n_first = 0;
        n_last  = 0;
        bus_big.we = 1'b0;
        for (int k = 0; k < 48; k++) begin
            n_checks++;
            if (bus_big.slot !== 5'(k % 24) || bus_big.dout !== 5'(k % 24 + 1) ||
                bus_big.tap !== 5'((k + 12) % 24 + 1))
                $display("FAIL ring k=%0d slot=%0d dout=%0d tap=%0d required slot=%0d dout=%0d tap=%0d",
                         k, bus_big.slot, bus_big.dout, bus_big.tap, k % 24, k % 24 + 1, (k + 12) % 24 + 1);
            else n_pass++;
            if (bus_big.first === 1'b1) n_first++;
            if (bus_big.last === 1'b1) n_last++;
            bus_big.din = 5'h0A;
            tick_big();
        end
        n_checks++;
        if (n_first != 2 || n_last != 2)
            $display("FAIL ring_flags first_count=%0d last_count=%0d required 2 and 2", n_first, n_last);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 5; k++) tick_big();
        n_checks++;
        if (bus_big.slot !== 5'd5)
            $display("FAIL clr_setup slot=%0d required 5", bus_big.slot);
        else n_pass++;
        bus_big.clr = 1'b1;
        bus_big.we  = 1'b1;
        bus_big.din = 5'd7;
        tick_big();
        bus_big.clr = 1'b0;
        bus_big.we  = 1'b0;
        for (int k = 1; k < 24; k++) begin
            if (k == 12) begin
                n_checks++;
                if (bus_big.tap !== RV)
                    $display("FAIL clr_tap tap=%h required %h", bus_big.tap, RV);
                else n_pass++;
            end
            tick_big();
        end
        for (int k = 0; k < 24; k++) begin
            int s;
            s = (k + 5) % 24;
            n_checks++;
            if (bus_big.slot !== 5'(s) || bus_big.dout !== ((s == 5) ? RV : 5'(s + 1)))
                $display("FAIL clr_ring slot=%0d dout=%h required slot=%0d dout=%h",
                         bus_big.slot, bus_big.dout, s, (s == 5) ? RV : 5'(s + 1));
            else n_pass++;
            tick_big();
        end
    endtask

    task automatic test_enable_gaps();
        for (int k = 0; k < 120; k++) begin
            bus_big.clk_en = 1'($urandom_range(0, 1));
            bus_big.we     = (k < 60);
            bus_big.clr    = (k < 60) && ($urandom_range(0, 9) == 0);
            bus_big.din    = 5'($urandom);
            tick_big();
            n_checks++;
            if (bus_big.dout !== m_stage[24] || bus_big.tap !== m_stage[12] ||
                bus_big.slot !== 5'(m_slot) || bus_big.first !== (m_slot == 0) ||
                bus_big.last !== (m_slot == 23))
                $display("FAIL gaps k=%0d dout=%h tap=%h slot=%0d first=%b last=%b required dout=%h tap=%h slot=%0d",
                         k, bus_big.dout, bus_big.tap, bus_big.slot, bus_big.first, bus_big.last,
                         m_stage[24], m_stage[12], m_slot);
            else n_pass++;
        end
        bus_big.clk_en = 1'b1;
        bus_big.we     = 1'b0;
        bus_big.clr    = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 24 && m_slot != 17; k++) tick_big();
        n_checks++;
        if (bus_big.slot !== 5'd17)
            $display("FAIL rmid_setup slot=%0d required 17", bus_big.slot);
        else n_pass++;
        rst_n_big   = 1'b0;
        bus_big.we  = 1'b1;
        bus_big.din = 5'd3;
        tick_big();
        rst_n_big  = 1'b1;
        bus_big.we = 1'b0;
        for (int k = 0; k < 24; k++) begin
            n_checks++;
            if (bus_big.slot !== 5'(k) || bus_big.dout !== RV || bus_big.tap !== RV ||
                bus_big.first !== (k == 0))
                $display("FAIL rmid_ring k=%0d slot=%0d dout=%h tap=%h first=%b required slot=%0d dout=tap=1f",
                         k, bus_big.slot, bus_big.dout, bus_big.tap, bus_big.first, k);
            else n_pass++;
            tick_big();
        end
    endtask

    task automatic test_small_ring();
        bus_small.clk_en = 1'b0;
        tick_small();
        n_checks++;
        if (bus_small.slot !== 2'd0 || bus_small.dout !== RV || bus_small.first !== 1'b1 || bus_small.last !== 1'b0)
            $display("FAIL small_reset slot=%0d dout=%h first=%b last=%b required 0 1f 1 0",
                     bus_small.slot, bus_small.dout, bus_small.first, bus_small.last);
        else n_pass++;
        rst_n_small      = 1'b1;
        bus_small.clk_en = 1'b1;
        bus_small.we     = 1'b1;
        bus_small.clr    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus_small.slot !== 2'(k) || bus_small.last !== (k == 2) || bus_small.dout !== RV)
                $display("FAIL small_fill k=%0d slot=%0d last=%b dout=%h required slot=%0d last=%b dout=1f",
                         k, bus_small.slot, bus_small.last, bus_small.dout, k, (k == 2));
            else n_pass++;
            bus_small.din = 5'(10 + k);
            tick_small();
        end
        bus_small.we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (bus_small.slot !== 2'(k % 3) || bus_small.dout !== 5'(10 + k % 3) ||
                bus_small.tap !== 5'(10 + k % 3))
                $display("FAIL small_ring k=%0d slot=%0d dout=%0d tap=%0d required slot=%0d dout=tap=%0d",
                         k, bus_small.slot, bus_small.dout, bus_small.tap, k % 3, 10 + k % 3);
            else n_pass++;
            tick_small();
        end
        tick_small();
        rst_n_small      = 1'b0;
        bus_small.clk_en = 1'b0;
        tick_small();
        rst_n_small      = 1'b1;
        bus_small.clk_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus_small.slot !== 2'(k % 3) || bus_small.dout !== RV)
                $display("FAIL small_rmid k=%0d slot=%0d dout=%h required slot=%0d dout=1f",
                         k, bus_small.slot, bus_small.dout, k % 3);
            else n_pass++;
            tick_small();
        end
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        m_slot           = 0;
        for (int i = 1; i <= 24; i++) m_stage[i] = RV;
        rst_n_big        = 1'b0;
        rst_n_small      = 1'b0;
        bus_big.clk_en   = 1'b0;
        bus_big.din      = '0;
        bus_big.we       = 1'b0;
        bus_big.clr      = 1'b0;
        bus_small.clk_en = 1'b0;
        bus_small.din    = '0;
        bus_small.we     = 1'b0;
        bus_small.clr    = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_recirculate();
        test_clear_priority();
        test_enable_gaps();
        test_reset_mid();
        test_small_ring();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jt12_sh_ring.md
Name: jt12_sh_ring

Overview:
- Parametrised, clock-enabled shift register for per-slot FM state, generalised from the fixed 24-stage, 5-bit pipeline.
- Adds configurable depth and width, synchronous reset to a programmable value, and a ring (recirculate) mode so a slot's value is kept until it is overwritten.
- Adds a selectable mid-chain tap, a free-running slot counter and cycle-boundary flags.
- Used by operator/channel pipelines that must hold per-slot registers across many sample cycles.

Parameters:
- WIDTH, 5, data bits per stage.
- STAGES, 24, ring depth; legal range 2..64.
- TAP, 12, stage number driven on tap, 1..STAGES; stage 1 is the first after din.
- RSTVAL, 0, WIDTH-bit value loaded into every stage at reset and on clear.
- SW, $clog2(STAGES), slot counter width; derived, not to be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- clk_en  in  1  advance enable; nothing except reset changes state while low
- din  in  WIDTH  new value for the current slot
- we  in  1  1: load din into stage 1; 0: recirculate the last stage into stage 1
- clr  in  1  load RSTVAL into stage 1; priority over we
- dout  out  WIDTH  last stage (stage STAGES)
- tap  out  WIDTH  stage TAP
- slot  out  SW  index of the slot currently presented at din/we/clr
- first  out  1  high while slot==0
- last  out  1  high while slot==STAGES-1

Behaviour:
- Storage: STAGES registers of WIDTH bits, stage 1..STAGES. dout and tap are direct register outputs; there is no extra output latency.
- Reset: on a clk rising edge with rst_n=0, regardless of clk_en:
  - every stage <= RSTVAL, so dout=tap=RSTVAL;
  - slot <= 0, so first=1 and last=0.
- Advance: on a clk edge with rst_n=1 and clk_en=1:
  - stage i <= stage i-1 for i=2..STAGES;
  - stage 1 <= RSTVAL if clr=1; else din if we=1; else stage STAGES;
  - slot <= 0 if slot==STAGES-1, else slot+1.
- Hold: rst_n=1 and clk_en=0 -> all state frozen; din, we and clr are ignored.
- Slot alignment: a value written while slot==s appears on dout exactly STAGES enabled edges later, when slot==s again. It appears on tap TAP enabled edges after the write.
- Ring mode (we=0, clr=0 every cycle) keeps contents indefinitely. The contents rotate with period STAGES enabled cycles.
- first and last are decoded combinationally from the slot register. Exactly one cycle per ring period has first=1, and likewise for last.
- Simultaneous clr=1 and we=1: clr wins and din is discarded.
- Reset mid-operation: every stage and the slot counter return to their reset values on that edge. There is no partial state.
- Reset with clk_en=0: still applies.
- Widths: no arithmetic on data. The slot counter wraps explicitly at STAGES-1, including non-power-of-two depths.
- Synthesis: clk_en is used as a direct clock enable. No asynchronous logic.

Test Plan:
- Reset: WIDTH=5, STAGES=24, RSTVAL=5'h1F, rst_n=0 for 2 clks, then rst_n=1 and clk_en=0 for 10 clks -> dout=tap=5'h1F, slot=0, first=1, last=0 throughout.
- Fill: clk_en=1, we=1, din=slot+1 for 24 cycles.
  - tap (TAP=12) shows 1 at the 12th enabled edge.
  - After the 24th edge, dout=1 with slot=0.
  - last=1 on the cycle before each wrap.
- Recirculate: after the fill, we=0 for 48 cycles -> dout equals slot+1 on every cycle. The sequence 1..24 repeats twice.
- Clear priority: in ring mode, assert clr=1 and we=1 with din=7 while slot==5 -> 24 edges later dout=RSTVAL with slot==5; all other slots are unchanged.
- Enable gaps: random clk_en with roughly 50% duty during a fill and then ring mode -> contents and slot match a reference model that counts enabled edges only.
- Reset mid-operation: rst_n=0 for one edge at slot==17 with a full ring -> next cycle all stages=RSTVAL and slot=0. Repeat with STAGES=3 and TAP=3 to check the small, non-power-of-two wrap (slot 0,1,2,0).
